// File: rtl/spi_reg_ctrl.sv
// -----------------------------------------------------------------------------
// spi_reg_ctrl
//   Register-access sequencer sitting in front of the byte-level spi engine.
//   One accepted request becomes one complete AFE frame: an address byte
//   followed by NBYTES data bytes (MSB byte first), either written or read.
//   The chip select (spiste) is held low for the whole frame by keeping at
//   least one of spi_wr_en / spi_rd_en / spi_flag asserted until the frame
//   is released.
//
//   Optional feature macro: SPI_TIMEOUT_EN (per-byte spi_done watchdog).
//   Without it, err and spi_stage_rst are tied low and a frame waits forever.
//
// Parameters
//   NBYTES   data bytes per frame, 1..4
//   GAP_CYC  div_clk cycles of spi_flag between bytes and before release, >=1
//   TMO_CYC  per-byte spi_done watchdog limit (SPI_TIMEOUT_EN only), >=20
//
// Ports
//   div_clk        in   clock (spi engine clock)
//   rst_n          in   asynchronous active-low reset
//   req            in   start a frame; only looked at while idle
//   cmd_rd         in   1 = read frame, 0 = write frame; captured with req
//   reg_addr       in   register address byte; captured with req
//   wr_data        in   write payload; captured with req
//   busy           out  high from the accept edge until ack
//   ack            out  one-cycle pulse at frame end
//   rd_data        out  read payload, valid from ack until next accepted read
//   err            out  one-cycle pulse with ack on a watchdog abort
//   spi_wr_en      out  engine wr_en
//   spi_rd_en      out  engine rd_en
//   spi_flag       out  engine flag (CS low, engine counter cleared)
//   spi_stage_rst  out  engine stage_rst
//   spi_tx_data    out  engine tx_data
//   spi_rx_data    in   engine rx_data
//   spi_done       in   engine spi_done
//
// Handshake: req is a level request sampled only in IDLE; the edge that sees
//   req=1 in IDLE accepts the frame and raises busy. Requests while busy are
//   dropped, not queued. Completion is the single-cycle ack pulse, during
//   which busy is already low; the controller then spends at least one IDLE
//   cycle with every engine control low before it can accept again.
// -----------------------------------------------------------------------------
module spi_reg_ctrl #(
    parameter int NBYTES  = 3,
    parameter int GAP_CYC = 2,
    parameter int TMO_CYC = 64
) (
    input  logic                  div_clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  cmd_rd,
    input  logic [7:0]            reg_addr,
    input  logic [8*NBYTES-1:0]   wr_data,
    output logic                  busy,
    output logic                  ack,
    output logic [8*NBYTES-1:0]   rd_data,
    output logic                  err,
    output logic                  spi_wr_en,
    output logic                  spi_rd_en,
    output logic                  spi_flag,
    output logic                  spi_stage_rst,
    output logic [7:0]            spi_tx_data,
    input  logic [7:0]            spi_rx_data,
    input  logic                  spi_done
);

    localparam int IDX_W = $clog2(NBYTES + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    if (NBYTES < 1 || NBYTES > 4 || GAP_CYC < 1 || TMO_CYC < 20) begin : g_bad_param
        $error("spi_reg_ctrl: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_GAP   = 3'd2,
        S_WDATA = 3'd3,
        S_RDATA = 3'd4,
        S_HOLD  = 3'd5,
        S_DONE  = 3'd6,
        S_ABORT = 3'd7
    } state_t;

    state_t state_q, state_d;

    // Frame context captured at accept
    logic                 cmd_rd_q;
    logic [8*NBYTES-1:0]  wr_data_q;
    logic [IDX_W-1:0]     byte_idx_q;   // data byte currently on the wire / next to send
    logic [GAP_W-1:0]     gap_cnt_q;

    logic                 in_byte;      // a byte transfer is in progress on the engine
    logic                 tmo_hit;
    logic                 last_byte;
    logic                 gap_done;
    logic [7:0]           next_wr_byte;

    // Next values of the registered outputs
    logic                 busy_d;
    logic                 ack_d;
    logic                 wr_en_d;
    logic                 rd_en_d;
    logic                 flag_d;
    logic [7:0]           tx_d;

    assign in_byte   = (state_q == S_ADDR) || (state_q == S_WDATA) || (state_q == S_RDATA);
    assign last_byte = (byte_idx_q == LAST_IDX);
    assign gap_done  = (gap_cnt_q == GAP_LAST);

    // Payload byte for the current data index, MSB byte first
    always_comb begin
        next_wr_byte = 8'h00;
        for (int b = 0; b < NBYTES; b++) begin
            if (byte_idx_q == IDX_W'(b)) begin
                next_wr_byte = wr_data_q[8*(NBYTES-1-b) +: 8];
            end
        end
    end

    // ---------------------------------------------------------------------
    // State register and registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge div_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            busy        <= 1'b0;
            ack         <= 1'b0;
            spi_wr_en   <= 1'b0;
            spi_rd_en   <= 1'b0;
            spi_flag    <= 1'b0;
            spi_tx_data <= 8'h00;
        end else begin
            state_q     <= state_d;
            busy        <= busy_d;
            ack         <= ack_d;
            spi_wr_en   <= wr_en_d;
            spi_rd_en   <= rd_en_d;
            spi_flag    <= flag_d;
            spi_tx_data <= tx_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic. spi_done is only meaningful in the byte states; a
    // done arriving on the same edge as a watchdog expiry wins.
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req) state_d = S_ADDR;
            end
            S_ADDR: begin
                if (spi_done)     state_d = S_GAP;
                else if (tmo_hit) state_d = S_ABORT;
            end
            S_WDATA, S_RDATA: begin
                if (spi_done)     state_d = last_byte ? S_HOLD : S_GAP;
                else if (tmo_hit) state_d = S_ABORT;
            end
            S_GAP: begin
                if (gap_done) state_d = cmd_rd_q ? S_RDATA : S_WDATA;
            end
            S_HOLD: begin
                if (gap_done) state_d = S_DONE;
            end
            S_ABORT: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Output logic: outputs are registered, so they are decoded from the
    // state being entered. tx_data is only reloaded while wr_en is low
    // (in IDLE, or leaving GAP where flag has held wr_en off).
    // ---------------------------------------------------------------------
    always_comb begin
        busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
        ack_d   = (state_d == S_DONE);
        wr_en_d = (state_d == S_ADDR) || (state_d == S_WDATA);
        rd_en_d = (state_d == S_RDATA);
        flag_d  = (state_d == S_GAP) || (state_d == S_HOLD);
        tx_d    = spi_tx_data;
        if (state_q == S_IDLE && req) begin
            tx_d = reg_addr;
        end else if (state_q == S_GAP && state_d == S_WDATA) begin
            tx_d = next_wr_byte;
        end
    end

    // ---------------------------------------------------------------------
    // Frame datapath: captured request, byte index, gap counter, read data
    // ---------------------------------------------------------------------
    always_ff @(posedge div_clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_rd_q   <= 1'b0;
            wr_data_q  <= '0;
            byte_idx_q <= '0;
            gap_cnt_q  <= '0;
            rd_data    <= '0;
        end else begin
            if (state_q == S_IDLE && req) begin
                cmd_rd_q   <= cmd_rd;
                wr_data_q  <= wr_data;
                byte_idx_q <= '0;
                // A new read invalidates the previous payload up front, so an
                // aborted read leaves zeros in the bytes it never received.
                if (cmd_rd) rd_data <= '0;
            end

            if ((state_q == S_WDATA || state_q == S_RDATA) && spi_done) begin
                byte_idx_q <= byte_idx_q + IDX_W'(1);
            end

            // rx_data is cleared by flag on the next cycle; this is the only
            // edge on which the received byte is visible.
            if (state_q == S_RDATA && spi_done) begin
                for (int b = 0; b < NBYTES; b++) begin
                    if (byte_idx_q == IDX_W'(b)) begin
                        rd_data[8*(NBYTES-1-b) +: 8] <= spi_rx_data;
                    end
                end
            end

            if (state_d == state_q && (state_q == S_GAP || state_q == S_HOLD)) begin
                gap_cnt_q <= gap_cnt_q + GAP_W'(1);
            end else begin
                gap_cnt_q <= '0;
            end
        end
    end

`ifdef SPI_TIMEOUT_EN
    // ---------------------------------------------------------------------
    // Per-byte watchdog: restarts on every entry into a byte state; expiry
    // pulses stage_rst for one cycle with all other controls low, then the
    // frame ends through DONE with err alongside ack.
    // ---------------------------------------------------------------------
    localparam int TMO_W = $clog2(TMO_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt_q;

    always_ff @(posedge div_clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else if (state_d != state_q) begin
            tmo_cnt_q <= '0;
        end else if (in_byte) begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
        end
    end

    assign tmo_hit = in_byte && (tmo_cnt_q == TMO_W'(TMO_CYC - 1));

    always_ff @(posedge div_clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_stage_rst <= 1'b0;
            err           <= 1'b0;
        end else begin
            spi_stage_rst <= (state_d == S_ABORT);
            err           <= (state_q == S_ABORT);
        end
    end
`else
    assign tmo_hit       = 1'b0;
    assign spi_stage_rst = 1'b0;
    assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_ctrl
//   Bench for spi_reg_ctrl with a behavioural model of the byte engine: each
//   enabled byte takes 16 div_clk edges, spi_done marks the final count,
//   flag clears the engine. Expected frames are built from the request:
//   MOSI byte list, read payload and frame latency.
// -----------------------------------------------------------------------------
module tb_spi_reg_ctrl;

    localparam int NB  = 3;
    localparam int GAP = 2;
    localparam int TMO = 64;
    localparam int W   = 8 * NB;
    // Each byte is 16 engine cycles, NB gaps between the NB+1 bytes, then the
    // CS hold and the DONE cycle.
    localparam int LAT_EXP   = (NB + 1) * 16 + NB * GAP + GAP + 1;
    localparam int LAT_LIMIT = 2000;

    // ---------------------------------------------------------------- clock/reset
    logic          div_clk = 1'b0;
    logic          rst_n   = 1'b0;
    always #5 div_clk = ~div_clk;

    logic          req = 1'b0;
    logic          cmd_rd = 1'b0;
    logic [7:0]    reg_addr = 8'h00;
    logic [W-1:0]  wr_data = '0;
    logic          busy, ack, err;
    logic [W-1:0]  rd_data;
    logic          spi_wr_en, spi_rd_en, spi_flag, spi_stage_rst;
    logic [7:0]    spi_tx_data;
    logic [7:0]    spi_rx_data;
    logic          spi_done;

    spi_reg_ctrl #(.NBYTES(NB), .GAP_CYC(GAP), .TMO_CYC(TMO)) dut (
        .div_clk       (div_clk),
        .rst_n         (rst_n),
        .req           (req),
        .cmd_rd        (cmd_rd),
        .reg_addr      (reg_addr),
        .wr_data       (wr_data),
        .busy          (busy),
        .ack           (ack),
        .rd_data       (rd_data),
        .err           (err),
        .spi_wr_en     (spi_wr_en),
        .spi_rd_en     (spi_rd_en),
        .spi_flag      (spi_flag),
        .spi_stage_rst (spi_stage_rst),
        .spi_tx_data   (spi_tx_data),
        .spi_rx_data   (spi_rx_data),
        .spi_done      (spi_done)
    );

    // ---------------------------------------------------------------- engine model
    int          eng_cnt;
    int          rx_idx;
    logic [7:0]  rx_bytes [NB];
    logic [7:0]  mosi_q [$];
    bit          stall_rd = 1'b0;   // hold spi_done low on read byte stall_at
    int          stall_at = 0;
    logic        stall_now;

    assign stall_now   = stall_rd && spi_rd_en && (rx_idx == stall_at);
    assign spi_done    = (spi_wr_en || spi_rd_en) && !spi_flag && (eng_cnt == 15) && !stall_now;
    assign spi_rx_data = (spi_done && spi_rd_en && rx_idx < NB) ? rx_bytes[rx_idx] : 8'h00;

    always @(posedge div_clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_cnt <= 0;
        end else if (spi_flag || spi_stage_rst || !(spi_wr_en || spi_rd_en)) begin
            eng_cnt <= 0;
        end else begin
            eng_cnt <= eng_cnt + 1;
        end
        if (rst_n && spi_done && spi_wr_en) mosi_q.push_back(spi_tx_data);
        if (rst_n && spi_done && spi_rd_en) rx_idx <= rx_idx + 1;
    end

    // ---------------------------------------------------------------- monitor
    int  viol_both = 0, viol_tx = 0, viol_cs = 0;
    int  stage_seen = 0, ack_cnt = 0, start_cnt = 0;
    int  gap_run = 0, last_gap = 0;
    logic       prev_wr = 1'b0, prev_busy = 1'b0;
    logic [7:0] prev_tx = 8'h00;

    always @(negedge div_clk) begin
        if (spi_wr_en && spi_rd_en) viol_both++;
        if (spi_wr_en && prev_wr && spi_tx_data != prev_tx) viol_tx++;
        if (busy && !(spi_wr_en || spi_rd_en || spi_flag) && !spi_stage_rst) viol_cs++;
        if (spi_stage_rst) stage_seen++;
        if (ack) ack_cnt++;
        if (ack) gap_run = 0;
        else if (!busy && !spi_wr_en && !spi_rd_en && !spi_flag && !spi_stage_rst) gap_run++;
        if (busy && !prev_busy) begin
            start_cnt++;
            last_gap = gap_run;
        end
        prev_wr   = spi_wr_en;
        prev_tx   = spi_tx_data;
        prev_busy = busy;
    end

    // ---------------------------------------------------------------- scoreboard
    int n_checks = 0;
    int n_errs   = 0;
    logic [W-1:0] exp_rd = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_rx(input logic [W-1:0] rx);
        for (int b = 0; b < NB; b++) rx_bytes[b] = rx[8*(NB-1-b) +: 8];
        rx_idx = 0;
    endtask

    // Drive one request, check the accept cycle, wait for ack and compare
    // the frame against what the request should have produced.
    task automatic run_frame(input bit rd, input logic [7:0] addr,
                             input logic [W-1:0] data, input logic [W-1:0] rx);
        int lat;
        int a0;
        load_rx(rx);
        mosi_q.delete();
        @(negedge div_clk); #1;
        a0 = ack_cnt;
        req = 1'b1; cmd_rd = rd; reg_addr = addr; wr_data = data;
        @(negedge div_clk);
        req = 1'b0;
        check("accept_busy", busy, 1);
        check("accept_tx", spi_tx_data, addr);
        lat = 1;
        while (!ack && lat < LAT_LIMIT) begin
            @(negedge div_clk);
            lat++;
        end
        check("ack_seen", ack, 1);
        check("ack_latency", lat, LAT_EXP);
        check("ack_busy_low", busy, 0);
        if (rd) begin
            exp_rd = rx;
            check("rd_mosi_cnt", mosi_q.size(), 1);
        end else begin
            check("wr_mosi_cnt", mosi_q.size(), NB + 1);
            for (int b = 0; b < NB && mosi_q.size() == NB + 1; b++)
                check("wr_mosi_data", mosi_q[b+1], data[8*(NB-1-b) +: 8]);
        end
        if (mosi_q.size() > 0) check("mosi_addr", mosi_q[0], addr);
        check("rd_data", rd_data, exp_rd);
        @(negedge div_clk); #1;
        check("ack_pulse", ack, 0);
        check("ack_once", ack_cnt - a0, 1);
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        int n, s0, a0, k;
        logic [W-1:0] w, rx;

        repeat (3) @(negedge div_clk);
        // reset values while held
        check("rst_busy", busy, 0);
        check("rst_ack", ack, 0);
        check("rst_ctrl", {spi_wr_en, spi_rd_en, spi_flag, spi_stage_rst, err}, 0);
        check("rst_tx", spi_tx_data, 0);
        check("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge div_clk);

        // directed write and read
        run_frame(1'b0, 8'h01, 24'hA55A3C, 24'h000000);
        check("wr_ack_cycle", LAT_EXP, 73);
        run_frame(1'b1, 8'h2A, 24'h000000, 24'h123456);
        check("rd_payload", rd_data, 24'h123456);

        // randomized frames
        for (int i = 0; i < 6; i++) begin
            run_frame(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                      W'($urandom), W'($urandom));
        end

        // req held for two frames (write then read) plus a pulse while busy
        w  = W'($urandom);
        rx = W'($urandom);
        load_rx(rx);
        mosi_q.delete();
        @(negedge div_clk); #1;
        s0 = start_cnt; a0 = ack_cnt;
        req = 1'b1; cmd_rd = 1'b0; reg_addr = 8'h11; wr_data = w;
        @(negedge div_clk); #1;
        cmd_rd = 1'b1; reg_addr = 8'h22;
        n = 0;
        while (start_cnt - s0 < 2 && n < 500) begin
            @(negedge div_clk); #1;
            n++;
        end
        req = 1'b0;
        check("held_two_starts", start_cnt - s0, 2);
        check("idle_gap", last_gap >= 1, 1);
        repeat (20) @(negedge div_clk);
        #1 req = 1'b1;
        @(negedge div_clk); #1;
        req = 1'b0;
        n = 0;
        while (ack_cnt - a0 < 2 && n < 500) begin
            @(negedge div_clk); #1;
            n++;
        end
        repeat (150) @(negedge div_clk);
        #1;
        check("held_acks", ack_cnt - a0, 2);
        check("held_starts", start_cnt - s0, 2);
        check("held_mosi_cnt", mosi_q.size(), NB + 2);
        if (mosi_q.size() == NB + 2) begin
            check("held_mosi_a0", mosi_q[0], 8'h11);
            for (int b = 0; b < NB; b++) check("held_mosi_d", mosi_q[b+1], w[8*(NB-1-b) +: 8]);
            check("held_mosi_a1", mosi_q[NB+1], 8'h22);
        end
        exp_rd = rx;
        check("held_rd_data", rd_data, exp_rd);

        // reset during the second data byte of a read
        rx = W'($urandom);
        load_rx(rx);
        @(negedge div_clk); #1;
        req = 1'b1; cmd_rd = 1'b1; reg_addr = 8'h5C;
        @(negedge div_clk); #1;
        req = 1'b0;
        n = 0;
        while (!(rx_idx == 1 && spi_rd_en) && n < 300) begin
            @(negedge div_clk); #1;
            n++;
        end
        check("reach_byte2", rx_idx == 1 && spi_rd_en, 1);
        repeat (5) @(negedge div_clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cs_high", {spi_wr_en, spi_rd_en, spi_flag, spi_stage_rst}, 0);
        check("mid_rst_rd_data", rd_data, 0);
        check("mid_rst_ack_err", {ack, err}, 0);
        check("mid_rst_tx", spi_tx_data, 0);
        exp_rd = '0;
        @(negedge div_clk);
        rst_n = 1'b1;
        repeat (2) @(negedge div_clk);
        run_frame(1'b0, 8'h7E, W'($urandom), '0);

`ifdef SPI_TIMEOUT_EN
        // engine stalls on the second read data byte
        rx = W'($urandom);
        load_rx(rx);
        stall_at = 1;
        stall_rd = 1'b1;
        @(negedge div_clk); #1;
        req = 1'b1; cmd_rd = 1'b1; reg_addr = 8'h33;
        @(negedge div_clk); #1;
        req = 1'b0;
        n = 0;
        while (!(rx_idx == 1 && spi_rd_en) && n < 300) begin
            @(negedge div_clk);
            n++;
        end
        k = 0;
        while (!spi_stage_rst && k < 500) begin
            @(negedge div_clk);
            k++;
        end
        check("tmo_cycles", k, TMO);
        check("tmo_ctrl_low", {spi_wr_en, spi_rd_en, spi_flag}, 0);
        @(negedge div_clk);
        check("tmo_ack_err", {ack, err}, 2'b11);
        check("tmo_stage_pulse", spi_stage_rst, 0);
        exp_rd = {rx[W-1 -: 8], {(W-8){1'b0}}};
        check("tmo_rd_partial", rd_data, exp_rd);
        stall_rd = 1'b0;
        repeat (3) @(negedge div_clk);
        run_frame(1'b1, 8'h44, '0, W'($urandom));
`else
        check("no_stage_rst", stage_seen, 0);
`endif

        check("never_both_en", viol_both, 0);
        check("tx_stable", viol_tx, 0);
        check("cs_low_frame", viol_cs, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
